mix_columns_seq: RTL and testbench
==================================

Name: mix_columns_seq

Overview:
Sequenced MixColumns engine for the AES-256 round datapath. It accepts a 128-bit state word over a valid/ready handshake. It then time-shares COLS_PER_CYCLE single-column mixers across the 4 state columns and returns the mixed state over a second valid/ready handshake. A per-transaction skip flag bypasses mixing for the final AES round, so the round controller always routes state through this block.

Parameters:
COLS_PER_CYCLE, 1, columns mixed per clock; legal values are 1, 2, 4. NCYC = 4/COLS_PER_CYCLE. Any other value is a fatal elaboration error.

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input state valid
in_ready  output  1  block can accept input
in_state  input  128  state; column c = in_state[127-32c -: 32], byte 0 of a column = its MSB byte
in_skip  input  1  sampled with in_state; 1 = pass state unmodified (final round)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_state  output  128  result, same column/byte ordering as in_state

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, col_idx=0, state register=0, out_state=0, out_valid=0, in_ready=1.
- Accept: a transfer occurs at a rising edge where in_valid & in_ready.
- in_ready = (FSM==IDLE) | (FSM==DONE & out_ready). This allows back-to-back transactions with no bubble on the input side.
- FSM states:
  - IDLE: on accept with skip=0, capture in_state, set col_idx=0, go to BUSY. On accept with skip=1, load out_state=in_state and go to DONE.
  - BUSY: each edge replaces columns col_idx .. col_idx+COLS_PER_CYCLE-1 of the state register with their mixed values, then advances col_idx by COLS_PER_CYCLE. On the edge that processes the last column, out_state takes the fully mixed state and the FSM goes to DONE. col_idx wraps to 0.
  - DONE: out_valid=1, and out_state is held stable while out_valid & !out_ready. If out_ready without accept, go to IDLE. If out_ready with a same-edge accept, follow the IDLE accept rules above (BUSY or DONE).
- Latency, accept edge to out_valid high:
  - skip=0: NCYC+1 edges (5 for COLS_PER_CYCLE=1, 3 for 2, 2 for 4).
  - skip=1: 1 edge.
- Throughput: one transaction per NCYC+1 cycles when out_ready is held high.
- Column math, per output byte: b0 = 2a0^3a1^a2^a3; b1 = a0^2a1^3a2^a3; b2 = a0^a1^2a2^3a3; b3 = 3a0^a1^a2^2a3.
  - Arithmetic is GF(2^8) with reduction polynomial 0x11B.
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1B : 8'h00); 3a = xtime(a)^a.
- in_valid and in_skip are ignored whenever in_ready=0. There is no abort input. Input-side stalls are allowed; in_state need not be held after the accept edge.
- out_valid, once raised, stays high until an out_ready handshake, regardless of inputs.
- Reset asserted mid-transaction drops the transaction immediately; no partial output is ever presented.
- With out_ready tied low in DONE, the block stalls indefinitely with in_ready=0 and no data loss.

Decomposition:
- Shared package aes_pkg holds:
  - typedefs: state_t (128), column_t (32), byte_t (8)
  - constant AES_POLY_LOW = 8'h1B
  - function xtime
- Sub-module mix_single_column: combinational, one column_t in and one column_t out.
  - Instantiated COLS_PER_CYCLE times. Instance k operates on column col_idx+k, selected by mux from the state register.
  - The same sub-module is reusable by the existing full-width MixColumns datapath.

Test Plan:
- FIPS-197 vector: in_state=128'hdb135345_f20a225c_01010101_c6c6c6c6, skip=0, out_ready=1 -> out_state=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6. out_valid rises exactly NCYC+1 edges after accept; run with COLS_PER_CYCLE=1, 2 and 4.
- Columns d4d4d4d5 and 2d26314c in slots 0 and 3 (others 0) -> result columns d5d5d7d6 and 4d7ebdf8; zero columns stay 0.
- in_skip=1 with in_state=128'h0123...cdef -> out_state equals the input 1 edge after accept. A following skip=0 transaction is unaffected by the skip.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Require out_state stable, out_valid=1, in_ready=0, and new in_valid ignored. Then pulse out_ready with in_valid=1: both handshakes complete on the same edge, and the second result is correct.
- Reset mid-BUSY: assert rst after 2 BUSY edges. Require out_valid=0, in_ready=1 and out_state=0 immediately, with no spurious out_valid after release.
- Random regression: 1000 random states with random skip, in_valid and out_ready stalls, checked against a reference model. Require no lost, duplicated or reordered results.

Source files
------------

// File: rtl/mix_columns_seq_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers for the sequenced MixColumns engine.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  column_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_fsm_t;

    localparam byte_t AES_POLY_LOW = 8'h1B;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY_LOW : 8'h00);
    endfunction

    function automatic byte_t mul3(input byte_t a);
        return xtime(a) ^ a;
    endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Input and output valid/ready handshakes of the sequenced MixColumns engine.
interface mix_columns_seq_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_state;
    logic   in_skip;
    logic   out_valid;
    logic   out_ready;
    state_t out_state;

    modport master (
        output in_valid, in_state, in_skip, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, in_skip, out_ready,
        output in_ready, out_valid, out_state
    );

endinterface

// File: rtl/mix_columns_seq_mix_single_column.sv
// Combinational MixColumns of one 32-bit column; byte 0 is the most significant byte.
module mix_single_column
    import aes_pkg::*;
(
    input  column_t i_col,
    output column_t o_col
);

    byte_t w_a0, w_a1, w_a2, w_a3;
    byte_t w_b0, w_b1, w_b2, w_b3;

    assign {w_a0, w_a1, w_a2, w_a3} = i_col;

    assign w_b0 = xtime(w_a0) ^ mul3(w_a1) ^ w_a2        ^ w_a3;
    assign w_b1 = w_a0        ^ xtime(w_a1) ^ mul3(w_a2) ^ w_a3;
    assign w_b2 = w_a0        ^ w_a1        ^ xtime(w_a2) ^ mul3(w_a3);
    assign w_b3 = mul3(w_a0)  ^ w_a1        ^ w_a2        ^ xtime(w_a3);

    assign o_col = {w_b0, w_b1, w_b2, w_b3};

endmodule

// File: rtl/mix_columns_seq.sv
// Sequenced MixColumns: mixes COLS_PER_CYCLE columns per clock, with a skip bypass for the final round.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input logic              clk,
    input logic              rst,
    mix_columns_seq_if.slave io_bus
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $fatal(1, "mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

    mc_fsm_t    r_fsm;
    logic [1:0] r_col_idx;
    state_t     r_state;
    state_t     r_out_state;
    logic       r_out_valid;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_last;
    logic [0:3][31:0] w_cols;
    logic [0:3][31:0] w_next_cols;
    state_t           w_next_state;
    logic [1:0]       w_idx   [COLS_PER_CYCLE];
    column_t          w_mixed [COLS_PER_CYCLE];

    // A finished result may be retired and a new state accepted on the same edge.
    assign w_in_ready = (r_fsm == ST_IDLE) | ((r_fsm == ST_DONE) & io_bus.out_ready);
    assign w_accept   = io_bus.in_valid & w_in_ready;
    assign w_last     = (r_col_idx == LAST_IDX);
    assign w_cols     = r_state;

    generate
        for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_mix
            assign w_idx[k] = r_col_idx + 2'(k);
            mix_single_column u_mix (
                .i_col (w_cols[w_idx[k]]),
                .o_col (w_mixed[k])
            );
        end
    endgenerate

    always_comb begin
        w_next_cols = w_cols;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            w_next_cols[w_idx[k]] = w_mixed[k];
        end
    end

    assign w_next_state = w_next_cols;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= ST_IDLE;
            r_col_idx   <= 2'd0;
            r_state     <= '0;
            r_out_state <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                ST_BUSY: begin
                    r_state   <= w_next_state;
                    r_col_idx <= r_col_idx + COL_STEP;
                    if (w_last) begin
                        r_col_idx   <= 2'd0;
                        r_out_state <= w_next_state;
                        r_out_valid <= 1'b1;
                        r_fsm       <= ST_DONE;
                    end
                end
                default: begin
                    if ((r_fsm == ST_DONE) && io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= ST_IDLE;
                    end
                    // Accepting from DONE implies out_ready, so this overrides the retire above.
                    if (w_accept) begin
                        if (io_bus.in_skip) begin
                            r_out_state <= io_bus.in_state;
                            r_out_valid <= 1'b1;
                            r_fsm       <= ST_DONE;
                        end else begin
                            r_state     <= io_bus.in_state;
                            r_col_idx   <= 2'd0;
                            r_fsm       <= ST_BUSY;
                        end
                    end
                end
            endcase
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_state = r_out_state;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: vectors, handshake corner cases and a random scoreboard run.
module tb_mix_columns_seq;
    import aes_pkg::*;

    localparam state_t FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam state_t FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam state_t COL_IN   = 128'hd4d4d4d5_00000000_00000000_2d26314c;
    localparam state_t COL_OUT  = 128'hd5d5d7d6_00000000_00000000_4d7ebdf8;
    localparam state_t SKIP_V   = 128'h0123456789abcdef0123456789abcdef;

    logic   clk;
    logic   rst;
    logic   d_valid;
    logic   d_skip;
    logic   d_oready;
    state_t d_state;

    int checks   = 0;
    int failures = 0;

    mix_columns_seq_if u_if1 ();
    mix_columns_seq_if u_if2 ();
    mix_columns_seq_if u_if4 ();

    assign u_if1.in_valid = d_valid;  assign u_if1.in_state = d_state;
    assign u_if1.in_skip  = d_skip;   assign u_if1.out_ready = d_oready;
    assign u_if2.in_valid = d_valid;  assign u_if2.in_state = d_state;
    assign u_if2.in_skip  = d_skip;   assign u_if2.out_ready = d_oready;
    assign u_if4.in_valid = d_valid;  assign u_if4.in_state = d_state;
    assign u_if4.in_skip  = d_skip;   assign u_if4.out_ready = d_oready;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .io_bus(u_if1));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .io_bus(u_if2));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .io_bus(u_if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: shift-and-add product followed by polynomial long division by 0x11B.
    function automatic byte_t gmul(input byte_t a, input byte_t b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic state_t ref_mix(input state_t s);
        byte_t  m [4][4];
        byte_t  a [4];
        byte_t  b;
        state_t r;
        m = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
              '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gmul(m[row][j], a[j]);
                r[127 - 32*c - 8*row -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic run_txn(input state_t s, input bit sk, output state_t res, output int lat);
        @(negedge clk);
        d_valid = 1'b1; d_state = s; d_skip = sk; d_oready = 1'b1;
        @(posedge clk); #1;
        d_valid = 1'b0;
        lat = 1;
        while (!u_if1.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = u_if1.out_state;
    endtask

    task automatic settle();
        @(negedge clk);
        d_valid = 1'b0; d_oready = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    typedef struct {
        state_t st;
        bit     skip;
        state_t exp;
    } vec_t;

    vec_t   vecs [5];
    state_t res, snap;
    state_t q [$];
    int     lat, n, acc, dlv, cyc;
    int     lat1, lat2, lat4;
    state_t r1, r2, r4;
    bit     spur;

    initial begin
        vecs[0] = '{FIPS_IN, 1'b0, FIPS_OUT};
        vecs[1] = '{COL_IN,  1'b0, COL_OUT};
        vecs[2] = '{SKIP_V,  1'b1, SKIP_V};
        vecs[3] = '{FIPS_IN, 1'b0, FIPS_OUT};
        vecs[4] = '{128'h0,  1'b0, 128'h0};

        rst = 1'b1; d_valid = 1'b0; d_skip = 1'b0; d_oready = 1'b0; d_state = '0;
        #12;
        chk("reset_out_valid", 128'(u_if1.out_valid), 128'(0));
        chk("reset_in_ready",  128'(u_if1.in_ready),  128'(1));
        chk("reset_out_state", u_if1.out_state, 128'h0);
        @(negedge clk); rst = 1'b0;

        // FIPS vector on all three widths together, measuring accept-to-valid edges.
        @(negedge clk);
        d_valid = 1'b1; d_state = FIPS_IN; d_skip = 1'b0; d_oready = 1'b1;
        @(posedge clk); #1;
        d_valid = 1'b0;
        lat1 = 0; lat2 = 0; lat4 = 0; r1 = '0; r2 = '0; r4 = '0;
        for (int e = 1; e <= 10; e++) begin
            if (lat1 == 0 && u_if1.out_valid) begin lat1 = e; r1 = u_if1.out_state; end
            if (lat2 == 0 && u_if2.out_valid) begin lat2 = e; r2 = u_if2.out_state; end
            if (lat4 == 0 && u_if4.out_valid) begin lat4 = e; r4 = u_if4.out_state; end
            if (e < 10) begin @(posedge clk); #1; end
        end
        chk("fips_c1_data", r1, FIPS_OUT);
        chk("fips_c1_lat",  128'(lat1), 128'(5));
        chk("fips_c2_data", r2, FIPS_OUT);
        chk("fips_c2_lat",  128'(lat2), 128'(3));
        chk("fips_c4_data", r4, FIPS_OUT);
        chk("fips_c4_lat",  128'(lat4), 128'(2));
        settle();

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].st, vecs[i].skip, res, lat);
            chk($sformatf("vec%0d_data", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(vecs[i].skip ? 1 : 5));
        end
        settle();

        // Backpressure in DONE, then a same-edge retire and accept.
        @(negedge clk);
        d_oready = 1'b0; d_valid = 1'b1; d_state = FIPS_IN; d_skip = 1'b0;
        @(posedge clk); #1;
        d_valid = 1'b0;
        n = 0;
        while (!u_if1.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        snap = u_if1.out_state;
        chk("bp_first", snap, FIPS_OUT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            d_valid = 1'b1; d_state = SKIP_V; d_skip = 1'b0;
            #1;
            chk("bp_hold_state", u_if1.out_state, snap);
            chk("bp_hold_valid", 128'(u_if1.out_valid), 128'(1));
            chk("bp_in_ready",   128'(u_if1.in_ready),  128'(0));
        end
        @(negedge clk);
        d_oready = 1'b1; d_valid = 1'b1; d_state = COL_IN; d_skip = 1'b0;
        #1;
        chk("bp_pulse_ready", 128'(u_if1.in_ready), 128'(1));
        @(posedge clk); #1;
        d_valid = 1'b0;
        chk("bp_retired", 128'(u_if1.out_valid), 128'(0));
        n = 0;
        while (!u_if1.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp_second", u_if1.out_state, COL_OUT);
        settle();

        // Reset after two BUSY edges.
        @(negedge clk);
        d_valid = 1'b1; d_state = FIPS_IN; d_skip = 1'b0; d_oready = 1'b1;
        @(posedge clk); #1;
        d_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 128'(u_if1.out_valid), 128'(0));
        chk("rst_in_ready",  128'(u_if1.in_ready),  128'(1));
        chk("rst_out_state", u_if1.out_state, 128'h0);
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        spur = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (u_if1.out_valid) spur = 1'b1;
        end
        chk("rst_no_spurious", 128'(spur), 128'(0));
        run_txn(FIPS_IN, 1'b0, res, lat);
        chk("rst_recover", res, FIPS_OUT);
        settle();

        // Random regression against the reference model.
        acc = 0; dlv = 0; cyc = 0;
        while (acc < 1000 && cyc < 30000) begin
            @(negedge clk);
            d_valid  = ($urandom_range(0, 3) != 0);
            d_skip   = 1'($urandom_range(0, 1));
            d_state  = {$urandom(), $urandom(), $urandom(), $urandom()};
            d_oready = ($urandom_range(0, 3) != 0);
            #1;
            if (u_if1.out_valid && d_oready) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rand_extra: unexpected result %h with empty queue", u_if1.out_state);
                end else begin
                    chk("rand_data", u_if1.out_state, q.pop_front());
                    dlv++;
                end
            end
            if (d_valid && u_if1.in_ready) begin
                q.push_back(d_skip ? d_state : ref_mix(d_state));
                acc++;
            end
            cyc++;
        end
        @(negedge clk);
        d_valid = 1'b0; d_oready = 1'b1;
        for (int i = 0; i < 50 && q.size() > 0; i++) begin
            #1;
            if (u_if1.out_valid) begin
                chk("rand_data", u_if1.out_state, q.pop_front());
                dlv++;
            end
            @(negedge clk);
        end
        chk("rand_accepted", 128'(acc), 128'(1000));
        chk("rand_delivered", 128'(dlv), 128'(acc));
        chk("rand_queue_empty", 128'(q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
